// File: rtl/memory_arbiter_pkg.sv
// Shared types and defaults for the two-port byte memory arbiter.
package mem_arb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  // A lone requester always wins; under contention the favoured port wins.
  function automatic port_e pick_port(input logic req_a, input logic req_b,
                                      input port_e fav);
    if (req_a && !req_b) return PORT_A;
    if (req_b && !req_a) return PORT_B;
    return fav;
  endfunction

endpackage

// File: rtl/memory_arbiter_regfile.sv
// Byte storage: synchronous write, one access read port and one view read port.
module byte_regfile
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata,
  input  logic [ADDR_W-1:0] i_vaddr,
  output logic [DATA_W-1:0] o_vdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Storage write; reset clears every entry so an aborted write leaves no trace.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
  assign o_vdata = r_mem[i_vaddr];

endmodule

// File: rtl/memory_arbiter.sv
// Two-port round-robin arbiter sequencing reads and writes into a byte regfile.
module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  input  logic [ADDR_W-1:0] view_addr,
  output logic [DATA_W-1:0] view_data,
  output logic              busy
);

  state_e            r_state, w_state_nxt;
  port_e             r_owner, r_fav, w_pick;
  logic              r_we, w_take;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_a_rdata, r_b_rdata, w_rd_data;
  logic              w_access, w_wr_en;

  assign w_access = (r_state == ACCESS);
  assign w_wr_en  = w_access && r_we;

  byte_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_wr_en),
    .i_waddr (r_addr),
    .i_wdata (r_wdata),
    .i_raddr (r_addr),
    .o_rdata (w_rd_data),
    .i_vaddr (view_addr),
    .o_vdata (view_data)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, new-request capture and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_pick      = pick_port(a_req, b_req, r_fav);
    a_gnt       = 1'b0;
    b_gnt       = 1'b0;
    a_rvalid    = 1'b0;
    b_rvalid    = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        if (a_req || b_req) begin
          w_take      = 1'b1;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        busy        = 1'b1;
        a_gnt       = (r_owner == PORT_A);
        b_gnt       = (r_owner == PORT_B);
        w_state_nxt = RESP;
      end
      RESP: begin
        busy     = 1'b1;
        a_rvalid = !r_we && (r_owner == PORT_A);
        b_rvalid = !r_we && (r_owner == PORT_B);
        if (a_req || b_req) begin
          w_take      = 1'b1;
          w_state_nxt = ACCESS;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Latch the winning request's command so requesters may drop req after gnt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner <= PORT_A;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_take) begin
      r_owner <= w_pick;
      r_we    <= (w_pick == PORT_A) ? a_we    : b_we;
      r_addr  <= (w_pick == PORT_A) ? a_addr  : b_addr;
      r_wdata <= (w_pick == PORT_A) ? a_wdata : b_wdata;
    end
  end

  // Priority pointer flips toward the non-owner once an access executes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_fav <= PORT_A;
    else if (w_access) r_fav <= (r_owner == PORT_A) ? PORT_B : PORT_A;
  end

  // Per-port read result registers, held until that port's next read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else if (w_access && !r_we) begin
      if (r_owner == PORT_A) r_a_rdata <= w_rd_data;
      else                   r_b_rdata <= w_rd_data;
    end
  end

  assign a_rdata = r_a_rdata;
  assign b_rdata = r_b_rdata;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed and randomized checks of memory_arbiter against a transaction-level model.
module tb_memory_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [1:0] a_addr = 0, b_addr = 0, view_addr = 0;
  logic [7:0] a_wdata = 0, b_wdata = 0;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid, busy;
  logic [7:0] a_rdata, b_rdata, view_data;

  int n_pass = 0;
  int n_total = 0;

  // Transaction-level model: storage contents, favoured port, last read per port.
  logic [7:0] m_mem [4];
  int         m_fav_b;
  logic [7:0] m_rd [2];

  memory_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .view_addr(view_addr), .view_data(view_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_req = 0; b_req = 0;
    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < 4; i++) m_mem[i] = 8'h00;
    m_fav_b = 0;
    m_rd[0] = 8'h00; m_rd[1] = 8'h00;
  endtask

  task automatic chk_view(input string tag, input logic [1:0] addr, input logic [7:0] exp);
    view_addr = addr;
    #1;
    chk(tag, view_data, exp);
  endtask

  initial begin
    logic       rq [2];
    logic       we_v [2];
    logic [1:0] ad_v [2];
    logic [7:0] wd_v [2];
    int         first, own, n, cnt;

    // Reset state
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_gnt", {a_gnt, b_gnt, a_rvalid, b_rvalid}, 0);
    chk("rst_rdata", {a_rdata, b_rdata}, 0);
    tick();
    reset = 0;
    chk_view("rst_view3", 2'd3, 8'h00);

    // A writes A5 to entry 2
    a_req = 1; a_we = 1; a_addr = 2; a_wdata = 8'hA5;
    tick();
    chk("t1_agnt", a_gnt, 1);
    chk("t1_bgnt", b_gnt, 0);
    chk("t1_busy", busy, 1);
    a_req = 0;
    tick();
    chk("t1_agnt_pulse", a_gnt, 0);
    chk("t1_arvalid", a_rvalid, 0);
    chk_view("t1_view2", 2'd2, 8'hA5);
    tick();
    chk("t1_idle", busy, 0);

    // Contention straight after reset: A first, B two cycles later
    do_reset();
    a_req = 1; a_we = 1; a_addr = 0; a_wdata = 8'h11;
    b_req = 1; b_we = 1; b_addr = 1; b_wdata = 8'h22;
    tick();
    chk("t2_first_a", {a_gnt, b_gnt}, 2'b10);
    a_req = 0;
    tick();
    chk("t2_resp", {a_gnt, b_gnt, busy}, 3'b001);
    tick();
    chk("t2_then_b", {a_gnt, b_gnt}, 2'b01);
    b_req = 0;
    tick();
    chk_view("t2_view0", 2'd0, 8'h11);
    chk_view("t2_view1", 2'd1, 8'h22);
    tick();
    chk("t2_idle", busy, 0);

    // B reads entry 1
    b_req = 1; b_we = 0; b_addr = 1;
    tick();
    chk("t3_bgnt", b_gnt, 1);
    b_req = 0;
    tick();
    chk("t3_brvalid", b_rvalid, 1);
    chk("t3_brdata", b_rdata, 8'h22);
    chk("t3_arvalid", a_rvalid, 0);
    tick();
    chk("t3_brvalid_pulse", b_rvalid, 0);
    chk("t3_brdata_hold", b_rdata, 8'h22);

    // Both hold req for four grants: A, B, A, B, one every 2 cycles
    a_req = 1; a_we = 1; a_addr = 2; a_wdata = 8'h33;
    b_req = 1; b_we = 1; b_addr = 3; b_wdata = 8'h44;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk("t4_grant", {a_gnt, b_gnt}, (g % 2 == 0) ? 2'b10 : 2'b01);
      chk("t4_busy_acc", busy, 1);
      if (g == 3) begin a_req = 0; b_req = 0; end
      tick();
      chk("t4_gap", {a_gnt, b_gnt}, 2'b00);
      chk("t4_busy_resp", busy, 1);
    end
    tick();
    chk("t4_idle", busy, 0);
    chk_view("t4_view2", 2'd2, 8'h33);
    chk_view("t4_view3", 2'd3, 8'h44);

    // Reset during ACCESS of a write to entry 3
    a_req = 1; a_we = 1; a_addr = 3; a_wdata = 8'hFF;
    tick();
    chk("t5_agnt", a_gnt, 1);
    reset = 1;
    #1;
    chk("t5_outs", {a_gnt, b_gnt, a_rvalid, b_rvalid, busy}, 0);
    chk("t5_rdata", {a_rdata, b_rdata}, 0);
    chk_view("t5_view3", 2'd3, 8'h00);
    tick();
    reset = 0; a_req = 0;
    tick();
    chk("t5_after", {a_gnt, b_gnt, a_rvalid, b_rvalid, busy}, 0);
    chk_view("t5_view3_after", 2'd3, 8'h00);
    chk_view("t5_view2_cleared", 2'd2, 8'h00);

    // Single port holds req: re-grant exactly 2 cycles later
    a_req = 1; a_we = 1; a_addr = 1; a_wdata = 8'h5A;
    tick();
    chk("t6_gnt1", a_gnt, 1);
    tick();
    chk("t6_gap", a_gnt, 0);
    tick();
    chk("t6_gnt2", a_gnt, 1);
    a_req = 0;
    tick();
    tick();
    chk("t6_idle", busy, 0);
    chk_view("t6_view1", 2'd1, 8'h5A);

    // Randomized transactions against the model
    do_reset();
    for (int it = 0; it < 60; it++) begin
      rq[0] = $urandom_range(0, 1);
      rq[1] = $urandom_range(0, 1);
      if (!rq[0] && !rq[1]) rq[$urandom_range(0, 1)] = 1;
      for (int p = 0; p < 2; p++) begin
        we_v[p] = $urandom_range(0, 1);
        ad_v[p] = 2'($urandom_range(0, 3));
        wd_v[p] = 8'($urandom);
      end
      a_req = rq[0]; a_we = we_v[0]; a_addr = ad_v[0]; a_wdata = wd_v[0];
      b_req = rq[1]; b_we = we_v[1]; b_addr = ad_v[1]; b_wdata = wd_v[1];
      first = (rq[0] && rq[1]) ? m_fav_b : (rq[0] ? 0 : 1);
      n = (rq[0] && rq[1]) ? 2 : 1;
      for (int k = 0; k < n; k++) begin
        own = (k == 0) ? first : 1 - first;
        tick();
        cnt = 0;
        while (!(a_gnt || b_gnt) && cnt < 4) begin tick(); cnt++; end
        chk("rnd_gnt_seen", a_gnt | b_gnt, 1);
        chk("rnd_owner", {a_gnt, b_gnt}, (own == 0) ? 2'b10 : 2'b01);
        if (own == 0) a_req = 0; else b_req = 0;
        if (we_v[own]) m_mem[ad_v[own]] = wd_v[own];
        else           m_rd[own] = m_mem[ad_v[own]];
        m_fav_b = (own == 0) ? 1 : 0;
        tick();
        chk("rnd_rvalid", {a_rvalid, b_rvalid},
            we_v[own] ? 2'b00 : ((own == 0) ? 2'b10 : 2'b01));
        chk("rnd_a_rdata", a_rdata, m_rd[0]);
        chk("rnd_b_rdata", b_rdata, m_rd[1]);
      end
      tick();
      chk("rnd_idle", busy, 0);
      for (int v = 0; v < 4; v++) chk_view("rnd_view", 2'(v), m_mem[v]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
